sdram_port_arbiter: RTL and testbench

Two-requester round-robin arbiter that shares the single SDRAM controller request port between the Wishbone-side memory bridge (port 0) and the DMA engine (port 1). It serialises requests into the controller's one-deep in_valid/busy handshake. It records the owner of every outstanding read in an in-order tag FIFO, so each returning read word is routed back to the port that issued it.

---
 rtl/sdram_port_arbiter_if.sv | 49 ++++
 rtl/sdram_port_arbiter.sv | 133 +++++++++++++
 tb/tb_sdram_port_arbiter.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/sdram_port_arbiter_if.sv
// Request/return bundle between the two requesters, the arbiter and the
// single-port SDRAM controller.
interface sdram_port_arbiter_if #(
    parameter int ADDR_W = 23,
    parameter int DATA_W = 32
);
    logic              p0_valid;
    logic              p0_rw;
    logic [ADDR_W-1:0] p0_addr;
    logic [DATA_W-1:0] p0_wdata;
    logic              p0_ack;
    logic              p0_rvalid;
    logic [DATA_W-1:0] p0_rdata;

    logic              p1_valid;
    logic              p1_rw;
    logic [ADDR_W-1:0] p1_addr;
    logic [DATA_W-1:0] p1_wdata;
    logic              p1_ack;
    logic              p1_rvalid;
    logic [DATA_W-1:0] p1_rdata;

    logic              sd_in_valid;
    logic              sd_rw;
    logic [ADDR_W-1:0] sd_addr;
    logic [DATA_W-1:0] sd_wdata;
    logic              sd_busy;
    logic              sd_out_valid;
    logic [DATA_W-1:0] sd_rdata;
    logic              err;

    modport slave (
        input  p0_valid, p0_rw, p0_addr, p0_wdata,
        input  p1_valid, p1_rw, p1_addr, p1_wdata,
        input  sd_busy, sd_out_valid, sd_rdata,
        output p0_ack, p0_rvalid, p0_rdata,
        output p1_ack, p1_rvalid, p1_rdata,
        output sd_in_valid, sd_rw, sd_addr, sd_wdata, err
    );

    modport master (
        output p0_valid, p0_rw, p0_addr, p0_wdata,
        output p1_valid, p1_rw, p1_addr, p1_wdata,
        output sd_busy, sd_out_valid, sd_rdata,
        input  p0_ack, p0_rvalid, p0_rdata,
        input  p1_ack, p1_rvalid, p1_rdata,
        input  sd_in_valid, sd_rw, sd_addr, sd_wdata, err
    );
endinterface

// File: rtl/sdram_port_arbiter.sv
// Round-robin arbiter sharing one SDRAM controller port between two
// requesters; an in-order tag FIFO routes read data back to its issuer.
module sdram_port_arbiter #(
    parameter int ADDR_W    = 23,
    parameter int DATA_W    = 32,
    parameter int TAG_DEPTH = 4
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_i,
    sdram_port_arbiter_if.slave bus
);
    localparam int PW = $clog2(TAG_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {IDLE, ISSUE, GAP} state_t;

    state_t            state, state_nxt;
    logic              last_grant, grant;
    logic              load, issue, push, pop;
    logic              full, empty, elig0, elig1, pick;
    logic [CW-1:0]     count;
    logic [PW-1:0]     wr_ptr, rd_ptr;
    logic [TAG_DEPTH-1:0] tags;
    logic              head;

    logic              sd_rw_q;
    logic [ADDR_W-1:0] sd_addr_q;
    logic [DATA_W-1:0] sd_wdata_q;
    logic              p0_rvalid_q, p1_rvalid_q;
    logic [DATA_W-1:0] p0_rdata_q, p1_rdata_q;
    logic              err_q;

    assign full  = (count == CW'(TAG_DEPTH));
    assign empty = (count == '0);
    assign elig0 = bus.p0_valid & (bus.p0_rw | ~full);
    assign elig1 = bus.p1_valid & (bus.p1_rw | ~full);
    assign pick  = (elig0 & elig1) ? ~last_grant : elig1;
    assign head  = tags[rd_ptr];
    assign push  = issue & ~sd_rw_q;
    assign pop   = bus.sd_out_valid & ~empty;

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        issue     = 1'b0;
        unique case (state)
            IDLE: begin
                if (!bus.sd_busy && (elig0 || elig1)) begin
                    load      = 1'b1;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                issue     = 1'b1;
                state_nxt = GAP;
            end
            GAP:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            grant      <= 1'b0;
            sd_rw_q    <= 1'b0;
            sd_addr_q  <= '0;
            sd_wdata_q <= '0;
        end else begin
            state <= state_nxt;
            if (load) begin
                grant      <= pick;
                last_grant <= pick;
                sd_rw_q    <= pick ? bus.p1_rw    : bus.p0_rw;
                sd_addr_q  <= pick ? bus.p1_addr  : bus.p0_addr;
                sd_wdata_q <= pick ? bus.p1_wdata : bus.p0_wdata;
            end
        end
    end

    // Tag FIFO: one bit per outstanding read, the port that issued it.
    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            tags   <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                tags[wr_ptr] <= grant;
                wr_ptr       <= wr_ptr + PW'(1);
            end
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            if (push && !pop)
                count <= count + CW'(1);
            else if (pop && !push)
                count <= count - CW'(1);
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            p0_rvalid_q <= 1'b0;
            p1_rvalid_q <= 1'b0;
            p0_rdata_q  <= '0;
            p1_rdata_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            p0_rvalid_q <= pop & ~head;
            p1_rvalid_q <= pop & head;
            if (pop && !head)
                p0_rdata_q <= bus.sd_rdata;
            if (pop && head)
                p1_rdata_q <= bus.sd_rdata;
            if (bus.sd_out_valid && empty)
                err_q <= 1'b1;
        end
    end

    assign bus.sd_in_valid = issue;
    assign bus.sd_rw       = sd_rw_q;
    assign bus.sd_addr     = sd_addr_q;
    assign bus.sd_wdata    = sd_wdata_q;
    assign bus.p0_ack      = issue & ~grant;
    assign bus.p1_ack      = issue & grant;
    assign bus.p0_rvalid   = p0_rvalid_q;
    assign bus.p1_rvalid   = p1_rvalid_q;
    assign bus.p0_rdata    = p0_rdata_q;
    assign bus.p1_rdata    = p1_rdata_q;
    assign bus.err         = err_q;
endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed cycle-by-cycle vectors for sdram_port_arbiter plus a
// hand-written async reset check.
module tb_sdram_port_arbiter;
    logic clk;
    logic rst_n;

    sdram_port_arbiter_if #(.ADDR_W(23), .DATA_W(32)) bus ();

    sdram_port_arbiter #(
        .ADDR_W(23), .DATA_W(32), .TAG_DEPTH(4)
    ) dut (
        .wb_clk_i(clk),
        .wb_rst_i(rst_n),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst_n;
        logic        v0, rw0;
        logic [22:0] a0;
        logic [31:0] w0;
        logic        v1, rw1;
        logic [22:0] a1;
        logic [31:0] w1;
        logic        busy, ov;
        logic [31:0] rd;
        logic        e_iv, e_rw;
        logic [22:0] e_addr;
        logic [31:0] e_wd;
        logic [1:0]  e_ack, e_rv;
        logic [31:0] e_rd0, e_rd1;
        logic        e_err;
    } vec_t;

    vec_t q[$];
    vec_t c;
    int   n_cmp;
    int   n_bad;

    // Appends n copies of the current inputs with the given expectations.
    task automatic row(input logic ov, input logic [31:0] rd,
                       input logic iv, input logic [1:0] ack,
                       input logic [1:0] rv, input logic err,
                       input int n = 1);
        for (int k = 0; k < n; k++) begin
            c.ov    = ov;
            c.rd    = rd;
            c.e_iv  = iv;
            c.e_ack = ack;
            c.e_rv  = rv;
            c.e_err = err;
            q.push_back(c);
        end
        c.ov = 1'b0;
    endtask

    task automatic rst_row();
        c.rst_n  = 1'b0;
        c.v0     = 1'b0;
        c.v1     = 1'b0;
        c.busy   = 1'b0;
        c.e_rw   = 1'b0;
        c.e_addr = '0;
        c.e_wd   = '0;
        c.e_rd0  = '0;
        c.e_rd1  = '0;
        row(0, 0, 0, 2'b00, 2'b00, 0);
        c.rst_n  = 1'b1;
    endtask

    task automatic check(input string name,
                         input logic [125:0] act,
                         input logic [125:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic build();
        c = '{default: '0};
        rst_row();

        // single read from port 0, data returns later
        c.v0 = 1; c.rw0 = 0; c.a0 = 23'h10;
        c.e_rw = 0; c.e_addr = 23'h10;
        row(0, 0, 1, 2'b01, 2'b00, 0);
        c.v0 = 0;
        row(0, 0, 0, 2'b00, 2'b00, 0, 4);
        c.e_rd0 = 32'hDEADBEEF;
        row(1, 32'hDEADBEEF, 0, 2'b00, 2'b01, 0);
        row(0, 0, 0, 2'b00, 2'b00, 0);

        // alternating reads from both ports
        rst_row();
        c.v0 = 1; c.rw0 = 0; c.a0 = 23'h100;
        c.v1 = 1; c.rw1 = 0; c.a1 = 23'h200;
        c.e_addr = 23'h100;
        row(0, 0, 1, 2'b01, 2'b00, 0);
        row(0, 0, 0, 2'b00, 2'b00, 0, 2);
        c.e_addr = 23'h200;
        row(0, 0, 1, 2'b10, 2'b00, 0);
        row(0, 0, 0, 2'b00, 2'b00, 0, 2);
        c.e_addr = 23'h100;
        row(0, 0, 1, 2'b01, 2'b00, 0);
        c.v0 = 0;
        row(0, 0, 0, 2'b00, 2'b00, 0, 2);
        c.e_addr = 23'h200;
        row(0, 0, 1, 2'b10, 2'b00, 0);
        c.v1 = 0;
        row(0, 0, 0, 2'b00, 2'b00, 0, 2);
        c.e_rd0 = 32'hA0;
        row(1, 32'hA0, 0, 2'b00, 2'b01, 0);
        c.e_rd1 = 32'hB1;
        row(1, 32'hB1, 0, 2'b00, 2'b10, 0);
        c.e_rd0 = 32'hA2;
        row(1, 32'hA2, 0, 2'b00, 2'b01, 0);
        c.e_rd1 = 32'hB3;
        row(1, 32'hB3, 0, 2'b00, 2'b10, 0);
        row(0, 0, 0, 2'b00, 2'b00, 0);

        // tag FIFO fills; writes still pass; freed slot used one cycle late
        c.v1 = 1; c.rw1 = 0; c.a1 = 23'h300;
        c.e_addr = 23'h300;
        for (int k = 0; k < 4; k++) begin
            row(0, 0, 1, 2'b10, 2'b00, 0);
            row(0, 0, 0, 2'b00, 2'b00, 0, 2);
        end
        row(0, 0, 0, 2'b00, 2'b00, 0, 2);
        c.v0 = 1; c.rw0 = 1; c.a0 = 23'h55; c.w0 = 32'h12345678;
        c.e_rw = 1; c.e_addr = 23'h55; c.e_wd = 32'h12345678;
        row(0, 0, 1, 2'b01, 2'b00, 0);
        c.v0 = 0; c.w0 = 0;
        row(0, 0, 0, 2'b00, 2'b00, 0, 3);
        c.e_rd1 = 32'hC0;
        row(1, 32'hC0, 0, 2'b00, 2'b10, 0);
        c.e_rw = 0; c.e_addr = 23'h300; c.e_wd = 0;
        row(0, 0, 1, 2'b10, 2'b00, 0);
        c.v1 = 0;
        row(0, 0, 0, 2'b00, 2'b00, 0, 2);
        for (int k = 0; k < 4; k++) begin
            c.e_rd1 = 32'hD0 + 32'(k);
            row(1, 32'hD0 + 32'(k), 0, 2'b00, 2'b10, 0);
        end
        row(0, 0, 0, 2'b00, 2'b00, 0);

        // controller busy holds off both ports
        c.v0 = 1; c.rw0 = 0; c.a0 = 23'h400;
        c.v1 = 1; c.rw1 = 0; c.a1 = 23'h500;
        c.busy = 1;
        row(0, 0, 0, 2'b00, 2'b00, 0, 10);
        c.busy = 0; c.e_addr = 23'h400;
        row(0, 0, 1, 2'b01, 2'b00, 0);
        c.v0 = 0; c.busy = 1;
        row(0, 0, 0, 2'b00, 2'b00, 0);
        c.busy = 0;
        row(0, 0, 0, 2'b00, 2'b00, 0);
        c.e_addr = 23'h500;
        row(0, 0, 1, 2'b10, 2'b00, 0);
        c.v1 = 0;
        row(0, 0, 0, 2'b00, 2'b00, 0, 2);
        c.e_rd0 = 32'hE0;
        row(1, 32'hE0, 0, 2'b00, 2'b01, 0);
        c.e_rd1 = 32'hE1;
        row(1, 32'hE1, 0, 2'b00, 2'b10, 0);

        // return with nothing outstanding
        row(1, 32'h1234, 0, 2'b00, 2'b00, 1);
        row(0, 0, 0, 2'b00, 2'b00, 1, 2);

        // reset discards two outstanding tags
        rst_row();
        row(0, 0, 0, 2'b00, 2'b00, 0);
        c.v0 = 1; c.rw0 = 0; c.a0 = 23'h600;
        c.e_addr = 23'h600;
        row(0, 0, 1, 2'b01, 2'b00, 0);
        c.v0 = 0; c.v1 = 1; c.rw1 = 0; c.a1 = 23'h700;
        row(0, 0, 0, 2'b00, 2'b00, 0, 2);
        c.e_addr = 23'h700;
        row(0, 0, 1, 2'b10, 2'b00, 0);
        c.v1 = 0;
        row(0, 0, 0, 2'b00, 2'b00, 0);
        rst_row();
        row(0, 0, 0, 2'b00, 2'b00, 0);
        row(1, 32'hF0, 0, 2'b00, 2'b00, 1);
        row(1, 32'hF1, 0, 2'b00, 2'b00, 1);
    endtask

    task automatic drive(input vec_t v);
        rst_n            = v.rst_n;
        bus.p0_valid     = v.v0;
        bus.p0_rw        = v.rw0;
        bus.p0_addr      = v.a0;
        bus.p0_wdata     = v.w0;
        bus.p1_valid     = v.v1;
        bus.p1_rw        = v.rw1;
        bus.p1_addr      = v.a1;
        bus.p1_wdata     = v.w1;
        bus.sd_busy      = v.busy;
        bus.sd_out_valid = v.ov;
        bus.sd_rdata     = v.rd;
    endtask

    function automatic logic [125:0] actual();
        return {bus.sd_in_valid, bus.sd_rw, bus.sd_addr, bus.sd_wdata,
                bus.p1_ack, bus.p0_ack, bus.p1_rvalid, bus.p0_rvalid,
                bus.p0_rdata, bus.p1_rdata, bus.err};
    endfunction

    function automatic logic [125:0] expected(input vec_t v);
        return {v.e_iv, v.e_rw, v.e_addr, v.e_wd, v.e_ack, v.e_rv,
                v.e_rd0, v.e_rd1, v.e_err};
    endfunction

    initial begin
        logic got;
        n_cmp = 0;
        n_bad = 0;
        build();
        drive(q[0]);
        for (int i = 0; i < q.size(); i++) begin
            drive(q[i]);
            @(posedge clk);
            #1;
            check($sformatf("row%0d", i), actual(), expected(q[i]));
        end

        // async reset must clear outputs without waiting for a clock edge
        bus.sd_out_valid = 1'b0;
        bus.p0_valid     = 1'b1;
        bus.p0_rw        = 1'b1;
        bus.p0_addr      = 23'h7;
        bus.p0_wdata     = 32'hA5A5;
        got = 1'b0;
        for (int k = 0; k < 8 && !got; k++) begin
            @(posedge clk);
            #1;
            got = bus.p0_ack;
        end
        check("ack_wait", {125'd0, got}, 126'd1);
        check("pre_rst_addr", {103'd0, bus.sd_addr}, 126'h7);
        #2;
        rst_n        = 1'b0;
        bus.p0_valid = 1'b0;
        #1;
        check("async_rst", actual(), 126'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst", actual(), 126'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule
